serial_diff_ctrl: RTL and testbench

Bit-serial subtraction controller that computes `a - b` on WIDTH-bit unsigned operands by time-sharing one `fullDiff` cell over WIDTH clock cycles. It replaces the WIDTH-cell ripple chain where area matters more than latency. It sits between a requester (start/ready handshake) and the shared 1-bit difference cell, and sequences operand shifting, the borrow register and result assembly. Output format matches the ripple subtractor: a WIDTH+1-bit result with the final borrow in the MSB.

---
 rtl/serial_diff_ctrl_if.sv | 18 +
 rtl/serial_diff_ctrl.sv | 112 +++++++++++
 tb/tb_serial_diff_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_diff_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
// Handshake: a request is accepted on the rising edge where start=1 and
// ready=1. The requester must hold start until it sees ready. done is a
// one-cycle pulse, and dif is valid from the done cycle until the next done.
interface serial_diff_ctrl_if #(
   parameter int WIDTH = 6
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   dif;

   modport master (output start, a, b, input ready, busy, done, dif);
   modport slave  (input start, a, b, output ready, busy, done, dif);
endinterface

// File: rtl/serial_diff_ctrl.sv
// Bit-serial a-b: one shared full-difference cell is stepped over WIDTH cycles.
// The result is a WIDTH+1-bit two's-complement value with the final borrow in the MSB.
module full_diff (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_diff_ctrl #(
   parameter int WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_diff_ctrl_if.slave  bus,
   output logic [1:0]         fsm_state
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH:0]   dif_q;
   logic             d;
   logic             bout;

   full_diff u_cell (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (brw),
      .d    (d),
      .bout (bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         acc     <= '0;
         brw     <= 1'b0;
         cnt     <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dif_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa      <= bus.a;
                  sb      <= bus.b;
                  brw     <= 1'b0;
                  cnt     <= '0;
                  acc     <= '0;
                  state   <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               acc <= {d, acc[WIDTH-1:1]};
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               brw <= bout;
               cnt <= cnt + CW'(1);
               // The top bit and final borrow come straight from the cell, not from acc.
               if (cnt == LAST) begin
                  dif_q  <= {bout, d, acc[WIDTH-1:1]};
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.dif   = dif_q;
   assign fsm_state = state;
endmodule

// File: tb/tb_serial_diff_ctrl.sv
// Bench for serial_diff_ctrl: directed vectors, corner sequences, exhaustive sweep
// and random operations, all scored against an arithmetic model of a-b.
module tb_serial_diff_ctrl;
   localparam int W = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] fsm_state;

   serial_diff_ctrl_if #(.WIDTH(W)) bus ();

   serial_diff_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [W:0] exp_q[$];
   int acc_q[$];
   int done_cyc_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   dif;
   } vec_t;
   vec_t vec[8];

   // Reference: difference modulo 2^W, plus a borrow flag from an unsigned compare.
   function automatic logic [W:0] model(input int a, input int b);
      logic [W:0] r;
      r[W-1:0] = W'((a - b + (1 << W)) % (1 << W));
      r[W]     = (a < b);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done pops one expected result and one accept cycle.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst_n && bus.done) begin
         done_cnt++;
         done_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            check("sb_dif", bus.dif, exp_q.pop_front());
            check("sb_latency", cyc - acc_q.pop_front(), W);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      exp_q.push_back(model(int'(a), int'(b)));
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
         acc_q.delete();
      end
   endtask

   initial begin
      int busy_n;
      int done_n;
      int rdy_hi;
      int d0;
      int n_acc;

      vec[0] = '{a: 6'd13, b: 6'd9,  dif: 7'b0000100};
      vec[1] = '{a: 6'd9,  b: 6'd13, dif: 7'b1111100};
      vec[2] = '{a: 6'd0,  b: 6'd1,  dif: 7'b1111111};
      vec[3] = '{a: 6'd63, b: 6'd63, dif: 7'b0000000};
      vec[4] = '{a: 6'd63, b: 6'd0,  dif: 7'b0111111};
      vec[5] = '{a: 6'd0,  b: 6'd63, dif: 7'b1000001};
      vec[6] = '{a: 6'd32, b: 6'd33, dif: 7'b1111111};
      vec[7] = '{a: 6'd5,  b: 6'd2,  dif: 7'b0000011};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      #12;
      check("rst_ready", bus.ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_dif", bus.dif, 0);
      check("rst_state", fsm_state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic op: busy and done profile
      do_op(6'd13, 6'd9);
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.busy) busy_n++;
         if (bus.done) done_n++;
         @(negedge clk);
      end
      check("basic_busy_cycles", busy_n, 6);
      check("basic_done_pulses", done_n, 1);
      check("basic_dif", bus.dif, 7'b0000100);
      drain();

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         do_op(vec[i].a, vec[i].b);
         drain();
         check("vec_dif", bus.dif, vec[i].dif);
      end

      // Busy collision: second start during RUN is ignored
      d0 = done_cnt;
      do_op(6'd5, 6'd2);
      @(negedge clk);
      bus.a     = 6'd1;
      bus.b     = 6'd7;
      bus.start = 1'b1;
      check("collision_ready", bus.ready, 0);
      @(negedge clk);
      bus.start = 1'b0;
      rdy_hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) break;
         if (bus.ready) rdy_hi++;
         @(negedge clk);
      end
      check("collision_ready_before_done", rdy_hi, 0);
      repeat (10) @(negedge clk);
      check("collision_done_count", done_cnt - d0, 1);
      check("collision_dif", bus.dif, 7'b0000011);
      drain();

      // Reset in the third RUN cycle
      do_op(6'd40, 6'd3);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_ready", bus.ready, 1);
      check("midrst_dif", bus.dif, 0);
      check("midrst_done", bus.done, 0);
      exp_q.delete();
      acc_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      do_op(6'd20, 6'd7);
      drain();
      check("midrst_fresh_dif", bus.dif, model(20, 7));

      // Back-to-back with start held high
      done_cyc_q.delete();
      n_acc = 0;
      bus.start = 1'b1;
      for (int c = 0; c < 200 && n_acc < 6; c++) begin
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         if (bus.ready) begin
            exp_q.push_back(model(int'(bus.a), int'(bus.b)));
            acc_q.push_back(cyc + 1);
            n_acc++;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      drain();
      check("b2b_done_count", done_cyc_q.size(), 6);
      for (int i = 1; i < done_cyc_q.size(); i++)
         check("b2b_spacing", done_cyc_q[i] - done_cyc_q[i-1], W + 2);

      // Exhaustive sweep
      for (int a = 0; a < (1 << W); a++)
         for (int b = 0; b < (1 << W); b++)
            do_op(W'(a), W'(b));
      drain();

      // Random operations with random idle gaps
      for (int i = 0; i < 300; i++) begin
         do_op(W'($urandom), W'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
